// File: rtl/cp0_exc_unit_pkg.sv
// Shared CP0 definitions: register numbers, ExcCodes, excepttype encodings
// and Status/Cause bit positions.
package cp0_exc_unit_pkg;

   localparam logic [4:0] CP0_BADVADDR = 5'd8;
   localparam logic [4:0] CP0_COUNT    = 5'd9;
   localparam logic [4:0] CP0_COMPARE  = 5'd11;
   localparam logic [4:0] CP0_STATUS   = 5'd12;
   localparam logic [4:0] CP0_CAUSE    = 5'd13;
   localparam logic [4:0] CP0_EPC      = 5'd14;

   localparam logic [4:0] EXC_INT  = 5'h00;
   localparam logic [4:0] EXC_ADEL = 5'h04;
   localparam logic [4:0] EXC_ADES = 5'h05;
   localparam logic [4:0] EXC_SYS  = 5'h08;
   localparam logic [4:0] EXC_BP   = 5'h09;
   localparam logic [4:0] EXC_RI   = 5'h0A;
   localparam logic [4:0] EXC_OV   = 5'h0C;

   // Interrupt gets its own nonzero encoding so that 0 can mean "none".
   localparam logic [31:0] ET_NONE = 32'h0;
   localparam logic [31:0] ET_INT  = 32'h1;
   localparam logic [31:0] ET_ADEL = 32'h4;
   localparam logic [31:0] ET_ADES = 32'h5;
   localparam logic [31:0] ET_SYS  = 32'h8;
   localparam logic [31:0] ET_BP   = 32'h9;
   localparam logic [31:0] ET_RI   = 32'hA;
   localparam logic [31:0] ET_OV   = 32'hC;
   localparam logic [31:0] ET_ERET = 32'hE;

   localparam int ST_IE  = 0;
   localparam int ST_EXL = 1;
   localparam int CA_TI  = 30;
   localparam int CA_BD  = 31;
   localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

   typedef struct packed {
      logic adel_if;
      logic invalid;
      logic ov;
      logic syscall;
      logic brk;
      logic adel_d;
      logic ades_d;
      logic eret;
   } exc_flags_t;

   typedef enum logic [1:0] {BADV_KEEP, BADV_PC, BADV_DATA} badv_sel_t;

endpackage

// File: rtl/cp0_exc_unit_if.sv
// MEM-stage <-> CP0 bundle: exception flags, mtc0/mfc0 access, flush/redirect.
interface cp0_exc_unit_if;
   logic        valid_m;
   logic [31:0] pc_m;
   logic        in_delayslot_m;
   logic        adel_if_m;
   logic        invalid_m;
   logic        syscall_m;
   logic        break_m;
   logic        eret_m;
   logic        ov_m;
   logic        adel_d_m;
   logic        ades_d_m;
   logic [31:0] data_addr_m;
   logic        cp0_we;
   logic [4:0]  cp0_waddr;
   logic [31:0] cp0_wdata;
   logic [4:0]  cp0_raddr;
   logic [31:0] cp0_rdata;
   logic        flush;
   logic [31:0] new_pc;
   logic [31:0] excepttype;
   logic [31:0] epc_o;
   logic [31:0] status_o;
   logic [31:0] cause_o;

   modport master (
      output valid_m, pc_m, in_delayslot_m, adel_if_m, invalid_m, syscall_m, break_m,
             eret_m, ov_m, adel_d_m, ades_d_m, data_addr_m,
             cp0_we, cp0_waddr, cp0_wdata, cp0_raddr,
      input  cp0_rdata, flush, new_pc, excepttype, epc_o, status_o, cause_o
   );

   modport slave (
      input  valid_m, pc_m, in_delayslot_m, adel_if_m, invalid_m, syscall_m, break_m,
             eret_m, ov_m, adel_d_m, ades_d_m, data_addr_m,
             cp0_we, cp0_waddr, cp0_wdata, cp0_raddr,
      output cp0_rdata, flush, new_pc, excepttype, epc_o, status_o, cause_o
   );
endinterface

// File: rtl/cp0_exc_unit_exc_arbiter.sv
// Combinational priority resolver: picks the single exception taken this cycle.
module exc_arbiter
   import cp0_exc_unit_pkg::*;
(
   input  logic        valid,
   input  logic        int_pend,
   input  exc_flags_t  flags,
   output logic [31:0] excepttype,
   output logic [4:0]  exccode,
   output badv_sel_t   badv_sel
);
   always_comb begin
      excepttype = ET_NONE;
      exccode    = EXC_INT;
      badv_sel   = BADV_KEEP;
      if (valid) begin
         if (int_pend) begin
            excepttype = ET_INT;  exccode = EXC_INT;
         end else if (flags.adel_if) begin
            excepttype = ET_ADEL; exccode = EXC_ADEL; badv_sel = BADV_PC;
         end else if (flags.invalid) begin
            excepttype = ET_RI;   exccode = EXC_RI;
         end else if (flags.ov) begin
            excepttype = ET_OV;   exccode = EXC_OV;
         end else if (flags.syscall) begin
            excepttype = ET_SYS;  exccode = EXC_SYS;
         end else if (flags.brk) begin
            excepttype = ET_BP;   exccode = EXC_BP;
         end else if (flags.adel_d) begin
            excepttype = ET_ADEL; exccode = EXC_ADEL; badv_sel = BADV_DATA;
         end else if (flags.ades_d) begin
            excepttype = ET_ADES; exccode = EXC_ADES; badv_sel = BADV_DATA;
         end else if (flags.eret) begin
            excepttype = ET_ERET;
         end
      end
   end
endmodule

// File: rtl/cp0_exc_unit.sv
// CP0 register file plus precise-exception commit in the MEM stage.
module cp0_exc_unit
   import cp0_exc_unit_pkg::*;
#(
   parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
   parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [5:0]  int_i,
   cp0_exc_unit_if.slave bus
);
   logic [31:0] count_q, compare_q, status_q, epc_q, badvaddr_q, cause;
   logic        tick_q, ti_q, bd_q;
   logic [4:0]  exccode_q;
   logic [1:0]  ip_sw_q;
   logic [5:0]  ip_hw_q;

   logic        int_pend, exc_take, eret_take, mtc0;
   exc_flags_t  flags;
   logic [31:0] excepttype;
   logic [4:0]  exccode;
   badv_sel_t   badv_sel;

   // IP[7] merges the timer with the top hardware line.
   assign cause = {bd_q, ti_q, 14'd0, ti_q | ip_hw_q[5], ip_hw_q[4:0], ip_sw_q,
                   1'b0, exccode_q, 2'b00};

   assign int_pend = status_q[ST_IE] & ~status_q[ST_EXL] & (|(cause[15:8] & status_q[15:8]));

   assign flags = '{adel_if: bus.adel_if_m, invalid: bus.invalid_m, ov: bus.ov_m,
                    syscall: bus.syscall_m, brk: bus.break_m, adel_d: bus.adel_d_m,
                    ades_d: bus.ades_d_m, eret: bus.eret_m};

   // Gating valid with resetn drops flush the moment reset asserts.
   exc_arbiter u_arb (
      .valid      (bus.valid_m & resetn),
      .int_pend   (int_pend),
      .flags      (flags),
      .excepttype (excepttype),
      .exccode    (exccode),
      .badv_sel   (badv_sel)
   );

   assign eret_take = (excepttype == ET_ERET);
   assign exc_take  = (excepttype != ET_NONE) && !eret_take;
   // A faulting instruction must not commit its mtc0.
   assign mtc0      = bus.cp0_we && (excepttype == ET_NONE);

   assign bus.flush      = (excepttype != ET_NONE);
   assign bus.new_pc     = eret_take ? epc_q : EXC_VECTOR;
   assign bus.excepttype = excepttype;
   assign bus.epc_o      = epc_q;
   assign bus.status_o   = status_q;
   assign bus.cause_o    = cause;

   always_comb begin
      bus.cp0_rdata = 32'd0;
      case (bus.cp0_raddr)
         CP0_BADVADDR: bus.cp0_rdata = badvaddr_q;
         CP0_COUNT:    bus.cp0_rdata = count_q;
         CP0_COMPARE:  bus.cp0_rdata = compare_q;
         CP0_STATUS:   bus.cp0_rdata = status_q;
         CP0_CAUSE:    bus.cp0_rdata = cause;
         CP0_EPC:      bus.cp0_rdata = epc_q;
         default:      bus.cp0_rdata = 32'd0;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count_q    <= 32'd0;
         compare_q  <= 32'd0;
         status_q   <= STATUS_RST;
         epc_q      <= 32'd0;
         badvaddr_q <= 32'd0;
         tick_q     <= 1'b0;
         ti_q       <= 1'b0;
         bd_q       <= 1'b0;
         exccode_q  <= 5'd0;
         ip_sw_q    <= 2'd0;
         ip_hw_q    <= 6'd0;
      end else begin
         tick_q  <= ~tick_q;
         ip_hw_q <= int_i;

         if (mtc0 && bus.cp0_waddr == CP0_COUNT) count_q <= bus.cp0_wdata;
         else if (tick_q)                          count_q <= count_q + 32'd1;

         if (mtc0 && bus.cp0_waddr == CP0_COMPARE) begin
            compare_q <= bus.cp0_wdata;
            ti_q      <= 1'b0;
         end else if (count_q == compare_q && compare_q != 32'd0) begin
            ti_q <= 1'b1;
         end

         if (exc_take) begin
            status_q[ST_EXL] <= 1'b1;
            exccode_q        <= exccode;
            // A nested exception keeps the original return point.
            if (!status_q[ST_EXL]) begin
               bd_q  <= bus.in_delayslot_m;
               epc_q <= bus.in_delayslot_m ? bus.pc_m - 32'd4 : bus.pc_m;
            end
            case (badv_sel)
               BADV_PC:   badvaddr_q <= bus.pc_m;
               BADV_DATA: badvaddr_q <= bus.data_addr_m;
               default:   ;
            endcase
         end else if (eret_take) begin
            status_q[ST_EXL] <= 1'b0;
         end else if (mtc0) begin
            case (bus.cp0_waddr)
               CP0_STATUS: status_q <= (status_q & ~STATUS_WMASK) | (bus.cp0_wdata & STATUS_WMASK);
               CP0_CAUSE:  ip_sw_q  <= bus.cp0_wdata[9:8];
               CP0_EPC:    epc_q    <= bus.cp0_wdata;
               default:    ;
            endcase
         end
      end
   end
endmodule

// File: doc/cp0_exc_unit.md
Name: cp0_exc_unit

Overview:
- Coprocessor-0 register file and precise-exception resolver in the MEM stage.
- Consumes the decode-side control stream carried down the pipe: cp0_we/cp0_re, invalid-instruction flag, syscall/break/eret markers, and the overflow and address-error flags raised downstream.
- Resolves at most one exception per cycle, updates the CP0 state, and drives the pipeline flush and redirect PC.
- Serves mfc0 reads and mtc0 writes.

Parameters:
- EXC_VECTOR, 32'hBFC0_0380, redirect PC for every exception.
- STATUS_RST, 32'h0040_0000, Status reset value (BEV=1).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  asynchronous active-low reset.
- int_i  in  6  hardware interrupt lines, level-sensitive, sampled each cycle into Cause.IP[7:2].
- valid_m  in  1  MEM-stage instruction is real, not a bubble.
- pc_m  in  32  MEM-stage instruction PC.
- in_delayslot_m  in  1  MEM-stage instruction sits in a branch delay slot.
- adel_if_m  in  1  fetch address error.
- invalid_m  in  1  reserved-instruction flag from decode.
- syscall_m  in  1  syscall marker.
- break_m  in  1  break marker.
- eret_m  in  1  eret marker.
- ov_m  in  1  arithmetic overflow.
- adel_d_m  in  1  load address error.
- ades_d_m  in  1  store address error.
- data_addr_m  in  32  faulting data address.
- cp0_we  in  1  mtc0 write enable.
- cp0_waddr  in  5  write register number.
- cp0_wdata  in  32  write data.
- cp0_raddr  in  5  read register number.
- cp0_rdata  out  32  read data (combinational).
- flush  out  1  flush IF..MEM this cycle (combinational).
- new_pc  out  32  redirect target, valid when flush=1.
- excepttype  out  32  resolved exception code, one-hot-free encoding; 0 = none.
- epc_o, status_o, cause_o  out  32 each  current register values for hazard/debug.

Behaviour:
- Registers:
  - BadVAddr(8) is read-only.
  - Count(9)
  - Compare(11)
  - Status(12): writable bits IM[15:8], EXL[1], IE[0].
  - Cause(13): BD[31], TI[30], IP[15:8] with only IP[9:8] writable, ExcCode[6:2].
  - EPC(14)
  - Unlisted addresses read 0 and ignore writes.
- Reset values: Status=STATUS_RST; all other registers 0; the Count tick toggle is 0. All combinational outputs are derived from these values.
- Count:
  - A tick flip-flop toggles every cycle; Count increments when the tick is 1, i.e. at half rate.
  - An mtc0 write to Count overrides the increment in that cycle.
- Timer:
  - When Count==Compare and Compare!=0, TI is set to 1 and IP[7] = TI OR int_i[5].
  - An mtc0 write to Compare clears TI.
- Interrupt pending: Status.IE AND NOT Status.EXL AND ((Cause.IP & Status.IM) != 0). An interrupt is taken only when valid_m=1.
- Priority, highest first, and ExcCode:
  - interrupt 0x00
  - adel_if 0x04
  - invalid 0x0A
  - ov 0x0C
  - syscall 0x08
  - break 0x09
  - adel_d 0x04
  - ades_d 0x05
  - eret (excepttype 0x0E)
- All flags are qualified by valid_m.
- On any exception except eret, at the clock edge:
  - EXL←1.
  - BD←in_delayslot_m.
  - ExcCode←code.
  - EPC←in_delayslot_m ? pc_m-4 : pc_m.
  - BadVAddr←pc_m for adel_if, or data_addr_m for adel_d/ades_d; unchanged otherwise.
  - Combinationally in the same cycle: flush=1 and new_pc=EXC_VECTOR.
- eret: EXL←0; flush=1; new_pc=EPC (the current register value).
- Simultaneous mtc0 and exception in the same cycle: the exception wins and the mtc0 write is suppressed, because the faulting instruction must not commit.
- Exceptions while EXL=1 still update ExcCode and BadVAddr. EPC and BD are not updated when EXL was already 1.
- Reset mid-operation clears all state asynchronously; flush drops to 0 immediately.
- cp0_rdata reads the current register value; no write-to-read bypass. The forwarding unit owns mtc0→mfc0 hazards.

Decomposition:
- Shared package/header (alongside the existing configs.vh) holds:
  - CP0 register numbers
  - ExcCode constants
  - excepttype encodings
  - Status/Cause bit positions
- A single sub-module, exc_arbiter, implements the priority resolver. It is combinational: flags plus pending interrupt in, excepttype and code out.

Test Plan:
- Reset then idle 10 cycles → Count=5, Status=0x0040_0000, flush=0.
- syscall_m=1, pc_m=0xBFC0_1000, in_delayslot_m=0 → flush=1, new_pc=0xBFC0_0380, excepttype=0x08; next cycle EPC=0xBFC0_1000, Cause.ExcCode=8, Status.EXL=1.
- invalid_m=1 with ov_m=1, in_delayslot_m=1, pc_m=0xBFC0_2004 → ExcCode=0x0A, EPC=0xBFC0_2000, BD=1.
- ades_d_m=1, data_addr_m=0x8000_0003 → ExcCode=5, BadVAddr=0x8000_0003. Then eret_m=1 → new_pc=EPC, EXL=0.
- mtc0 Compare=4, Status=0x0000_8001 (IM7, IE), hold valid_m → interrupt taken once Count=4 with ExcCode=0. Then mtc0 to Compare → TI=0.
- mtc0 EPC=0x1234 in the same cycle as break_m=1 → EPC=pc_m, not 0x1234.
